// File: rtl/square_wave_meter.sv
// Square-wave meter: synchronises an asynchronous square wave and measures its
// period (rise to rise) and high time (rise to fall) in clk cycles. Each
// completed period is published with a one-cycle valid strobe. A missing
// rising edge for TIMEOUT cycles drops lock and raises timeout.
module square_wave_meter #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(1000000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StLocked
    } state_e;

    state_e state_q, state_d;

    logic s1_q, s2_q, s3_q;
    logic rise, fall;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] hcap_q;

    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic             cnt_expired;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sw;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    // Cycle counter: restarts at 1 on a rise so its value at an event equals
    // the number of cycles since that rise; saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (rise) begin
            cnt_q <= WIDTH'(1);
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    // High-time capture on the falling edge; always precedes the next rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcap_q <= '0;
        end else if (fall) begin
            hcap_q <= cnt_q;
        end
    end

    assign cnt_expired = (cnt_q == TIMEOUT);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state and output logic; a rise takes priority over expiry.
    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d   = StArmed;
                    timeout_d = 1'b0;
                end
            end
            StArmed: begin
                if (rise) begin
                    state_d     = StLocked;
                    period_d    = cnt_q;
                    high_time_d = hcap_q;
                    valid_d     = 1'b1;
                    locked_d    = 1'b1;
                end else if (cnt_expired) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
            end
            StLocked: begin
                if (rise) begin
                    period_d    = cnt_q;
                    high_time_d = hcap_q;
                    valid_d     = 1'b1;
                end else if (cnt_expired) begin
                    state_d   = StIdle;
                    locked_d  = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign timeout   = timeout_q;

endmodule
